// File: rtl/decoder_pkg.sv
// Shared types for the RV32I decode stage: opcodes, ALU operations, immediate
// formats and the registered decode bundle.
package decoder_pkg;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_BRANCH = 7'b1100011,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_OP_IMM = 7'b0010011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_FENCE  = 7'b0001111,
      OPC_SYSTEM = 7'b1110011
   } opcode_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4,
      IMM_R = 3'd5
   } imm_type_t;

   typedef struct packed {
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      alu_op_t    alu_op;
      logic [2:0] funct3;
      logic       is_load;
      logic       is_store;
      logic       is_branch;
      logic       is_jal;
      logic       is_jalr;
      logic       is_lui;
      logic       is_auipc;
      logic       is_system;
      logic       alu_imm;
      logic       illegal;
   } dec_t;

   // alt selects SUB/SRA over ADD/SRL (funct7[5])
   function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/decoder_if.sv
// Fetcher-to-decoder and decoder-to-executor handshakes plus the decoded bundle.
interface decoder_if;
   import decoder_pkg::*;

   logic        fetcher_valid;
   logic        decoder_ready;
   logic [31:0] instr;
   logic [31:0] fetcher_pc;

   logic        executor_ready;
   logic        decoder_valid;
   logic [31:0] decoder_pc;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   alu_op_t     alu_op;
   logic [2:0]  funct3;
   logic        is_load;
   logic        is_store;
   logic        is_branch;
   logic        is_jal;
   logic        is_jalr;
   logic        is_lui;
   logic        is_auipc;
   logic        is_system;
   logic        alu_imm;
   logic        illegal;

   // master: the environment around the decoder (fetcher + executor)
   modport master (
      output fetcher_valid, instr, fetcher_pc, executor_ready,
      input  decoder_ready, decoder_valid, decoder_pc, rd, rs1, rs2, imm,
             alu_op, funct3, is_load, is_store, is_branch, is_jal, is_jalr,
             is_lui, is_auipc, is_system, alu_imm, illegal
   );

   modport slave (
      input  fetcher_valid, instr, fetcher_pc, executor_ready,
      output decoder_ready, decoder_valid, decoder_pc, rd, rs1, rs2, imm,
             alu_op, funct3, is_load, is_store, is_branch, is_jal, is_jalr,
             is_lui, is_auipc, is_system, alu_imm, illegal
   );
endinterface

// File: rtl/decoder_imm_gen.sv
// Combinational RV32I immediate extraction; opcode bits are not needed here.
module decoder_imm_gen
   import decoder_pkg::*;
(
   input  logic [31:7] instr_hi,
   input  imm_type_t   imm_type,
   output logic [31:0] imm
);

   always_comb begin
      imm = 32'd0;
      case (imm_type)
         IMM_I: imm = {{20{instr_hi[31]}}, instr_hi[31:20]};
         IMM_S: imm = {{20{instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
         IMM_B: imm = {{19{instr_hi[31]}}, instr_hi[31], instr_hi[7],
                       instr_hi[30:25], instr_hi[11:8], 1'b0};
         IMM_U: imm = {instr_hi[31:12], 12'd0};
         IMM_J: imm = {{11{instr_hi[31]}}, instr_hi[31], instr_hi[19:12],
                       instr_hi[20], instr_hi[30:21], 1'b0};
         default: imm = 32'd0;
      endcase
   end

endmodule

// File: rtl/decoder.sv
// RV32I decode stage: single-entry registered slot between fetcher and executor,
// with flush on redirect. Illegal encodings still flow through marked illegal.
module decoder
   import decoder_pkg::*;
#(
   parameter int SUPPORT_SYSTEM = 1
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     flush,
   decoder_if.slave bus
);

   dec_t        d;
   imm_type_t   imm_type;
   logic [31:0] imm_c;
   logic        illegal_c;
   logic [6:0]  f7;
   logic [2:0]  f3;

   dec_t        q;
   logic [31:0] q_imm;
   logic [31:0] q_pc;
   logic        q_valid;
   logic        accept;

   assign f7 = bus.instr[31:25];
   assign f3 = bus.instr[14:12];

   always_comb begin
      d          = '0;
      imm_type   = IMM_R;
      illegal_c  = 1'b0;
      d.rs1      = bus.instr[19:15];
      d.rs2      = bus.instr[24:20];
      d.rd       = bus.instr[11:7];
      d.funct3   = f3;
      d.alu_op   = ALU_ADD;
      case (bus.instr[6:0])
         OPC_OP: begin
            illegal_c = (f7 != 7'b0000000) &&
                        !(f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            d.alu_op  = alu_from_f3(f3, f7[5]);
         end
         OPC_OP_IMM: begin
            imm_type  = IMM_I;
            d.alu_imm = 1'b1;
            // only the shift forms carry a funct7; ADDI and friends use the full imm
            if (f3 == 3'b001)
               illegal_c = (f7 != 7'b0000000);
            else if (f3 == 3'b101)
               illegal_c = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            d.alu_op  = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
         end
         OPC_LOAD: begin
            imm_type  = IMM_I;
            d.is_load = 1'b1;
            d.alu_imm = 1'b1;
            illegal_c = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OPC_STORE: begin
            imm_type   = IMM_S;
            d.is_store = 1'b1;
            d.alu_imm  = 1'b1;
            d.rd       = 5'd0;
            illegal_c  = (f3 >= 3'b011);
         end
         OPC_BRANCH: begin
            imm_type    = IMM_B;
            d.is_branch = 1'b1;
            d.rd        = 5'd0;
            illegal_c   = (f3 == 3'b010) || (f3 == 3'b011);
            d.alu_op    = (f3[2:1] == 2'b10) ? ALU_SLT :
                          (f3[2:1] == 2'b11) ? ALU_SLTU : ALU_SUB;
         end
         OPC_JAL: begin
            imm_type = IMM_J;
            d.is_jal = 1'b1;
         end
         OPC_JALR: begin
            imm_type  = IMM_I;
            d.is_jalr = 1'b1;
            d.alu_imm = 1'b1;
         end
         OPC_LUI: begin
            imm_type = IMM_U;
            d.is_lui = 1'b1;
         end
         OPC_AUIPC: begin
            imm_type   = IMM_U;
            d.is_auipc = 1'b1;
         end
         OPC_FENCE: begin
            // legal no-op for the executor: no class flag, no writeback
            imm_type  = IMM_I;
            d.rd      = 5'd0;
            illegal_c = (SUPPORT_SYSTEM == 0);
         end
         OPC_SYSTEM: begin
            imm_type    = IMM_I;
            d.is_system = 1'b1;
            d.rd        = 5'd0;
            illegal_c   = (SUPPORT_SYSTEM == 0);
         end
         default: illegal_c = 1'b1;
      endcase
      if (illegal_c) begin
         d.is_load   = 1'b0;
         d.is_store  = 1'b0;
         d.is_branch = 1'b0;
         d.is_jal    = 1'b0;
         d.is_jalr   = 1'b0;
         d.is_lui    = 1'b0;
         d.is_auipc  = 1'b0;
         d.is_system = 1'b0;
         d.alu_imm   = 1'b0;
         d.rd        = 5'd0;
      end
      d.illegal = illegal_c;
   end

   decoder_imm_gen u_imm_gen (
      .instr_hi (bus.instr[31:7]),
      .imm_type (imm_type),
      .imm      (imm_c)
   );

   assign bus.decoder_ready = !q_valid || bus.executor_ready;
   assign accept            = bus.fetcher_valid && bus.decoder_ready && !flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         q       <= '0;
         q_imm   <= 32'd0;
         q_pc    <= 32'd0;
         q_valid <= 1'b0;
      end else if (flush) begin
         q_valid <= 1'b0;
      end else if (accept) begin
         q       <= d;
         q_imm   <= imm_c;
         q_pc    <= bus.fetcher_pc;
         q_valid <= 1'b1;
      end else if (bus.executor_ready) begin
         q_valid <= 1'b0;
      end
   end

   assign bus.decoder_valid = q_valid;
   assign bus.decoder_pc    = q_pc;
   assign bus.imm           = q_imm;
   assign bus.rd            = q.rd;
   assign bus.rs1           = q.rs1;
   assign bus.rs2           = q.rs2;
   assign bus.alu_op        = q.alu_op;
   assign bus.funct3        = q.funct3;
   assign bus.is_load       = q.is_load;
   assign bus.is_store      = q.is_store;
   assign bus.is_branch     = q.is_branch;
   assign bus.is_jal        = q.is_jal;
   assign bus.is_jalr       = q.is_jalr;
   assign bus.is_lui        = q.is_lui;
   assign bus.is_auipc      = q.is_auipc;
   assign bus.is_system     = q.is_system;
   assign bus.alu_imm       = q.alu_imm;
   assign bus.illegal       = q.illegal;

endmodule

// File: tb/tb_decoder.sv
// Directed bench for the RV32I decode stage with hand-decoded expected values.
module tb_decoder;
   import decoder_pkg::*;

   localparam logic [7:0] F_NONE   = 8'h00;
   localparam logic [7:0] F_LOAD   = 8'h80;
   localparam logic [7:0] F_STORE  = 8'h40;
   localparam logic [7:0] F_BRANCH = 8'h20;
   localparam logic [7:0] F_JAL    = 8'h10;
   localparam logic [7:0] F_JALR   = 8'h08;
   localparam logic [7:0] F_LUI    = 8'h04;
   localparam logic [7:0] F_AUIPC  = 8'h02;
   localparam logic [7:0] F_SYSTEM = 8'h01;

   logic clk;
   logic reset;
   logic flush;
   int   n_tests;
   int   n_fail;

   decoder_if bus ();

   decoder #(.SUPPORT_SYSTEM(1)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] flags();
      return {bus.is_load, bus.is_store, bus.is_branch, bus.is_jal,
              bus.is_jalr, bus.is_lui, bus.is_auipc, bus.is_system};
   endfunction

   task automatic exp_dec(input string tag, input logic [31:0] pc, input logic [4:0] rd,
                          input logic [31:0] imm, input alu_op_t alu,
                          input logic [7:0] fl, input logic aimm, input logic ill);
      chk({tag, ".valid"},   32'(bus.decoder_valid), 32'd1);
      chk({tag, ".pc"},      bus.decoder_pc, pc);
      chk({tag, ".rd"},      32'(bus.rd), 32'(rd));
      chk({tag, ".imm"},     bus.imm, imm);
      chk({tag, ".alu_op"},  32'(bus.alu_op), 32'(alu));
      chk({tag, ".flags"},   32'(flags()), 32'(fl));
      chk({tag, ".alu_imm"}, 32'(bus.alu_imm), 32'(aimm));
      chk({tag, ".illegal"}, 32'(bus.illegal), 32'(ill));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] i, input logic [31:0] pc);
      bus.fetcher_valid = 1'b1;
      bus.instr         = i;
      bus.fetcher_pc    = pc;
      step();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset = 1'b1;
      flush = 1'b0;
      bus.fetcher_valid  = 1'b0;
      bus.instr          = 32'd0;
      bus.fetcher_pc     = 32'd0;
      bus.executor_ready = 1'b1;
      step();
      step();
      chk("rst.valid", 32'(bus.decoder_valid), 32'd0);
      chk("rst.rd",    32'(bus.rd), 32'd0);
      chk("rst.imm",   bus.imm, 32'd0);
      chk("rst.flags", 32'(flags()), 32'd0);
      reset = 1'b0;
      #1;
      chk("rst.ready", 32'(bus.decoder_ready), 32'd1);

      // ADDI x1,x2,-1
      send(32'hFFF10093, 32'h100);
      exp_dec("addi", 32'h100, 5'd1, 32'hFFFFFFFF, ALU_ADD, F_NONE, 1'b1, 1'b0);
      chk("addi.rs1", 32'(bus.rs1), 32'd2);

      // BEQ x0,x0,-4
      send(32'hFE000EE3, 32'h104);
      exp_dec("beq", 32'h104, 5'd0, 32'hFFFFFFFC, ALU_SUB, F_BRANCH, 1'b0, 1'b0);
      chk("beq.funct3", 32'(bus.funct3), 32'd0);

      // LUI x5,0x12345
      send(32'h123452B7, 32'h108);
      exp_dec("lui", 32'h108, 5'd5, 32'h12345000, ALU_ADD, F_LUI, 1'b0, 1'b0);

      // ADD x3,x1,x2 then backpressure with SUB x4,x1,x2 waiting
      send(32'h002081B3, 32'h10C);
      exp_dec("add", 32'h10C, 5'd3, 32'h0, ALU_ADD, F_NONE, 1'b0, 1'b0);
      chk("add.rs2", 32'(bus.rs2), 32'd2);
      bus.executor_ready = 1'b0;
      bus.instr          = 32'h40208233;
      bus.fetcher_pc     = 32'h110;
      #1;
      chk("bp.ready0", 32'(bus.decoder_ready), 32'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         exp_dec("bp.hold", 32'h10C, 5'd3, 32'h0, ALU_ADD, F_NONE, 1'b0, 1'b0);
         chk("bp.ready", 32'(bus.decoder_ready), 32'd0);
      end
      bus.executor_ready = 1'b1;
      #1;
      chk("bp.ready1", 32'(bus.decoder_ready), 32'd1);
      step();
      exp_dec("sub", 32'h110, 5'd4, 32'h0, ALU_SUB, F_NONE, 1'b0, 1'b0);

      // all-zero word and OP with funct7=1000000 are illegal
      send(32'h00000000, 32'h114);
      exp_dec("zero", 32'h114, 5'd0, 32'h0, ALU_ADD, F_NONE, 1'b0, 1'b1);
      send(32'h802082B3, 32'h118);
      exp_dec("badf7", 32'h118, 5'd0, 32'h0, ALU_ADD, F_NONE, 1'b0, 1'b1);

      // SRAI x6,x1,3
      send(32'h4030D313, 32'h11C);
      exp_dec("srai", 32'h11C, 5'd6, 32'h00000403, ALU_SRA, F_NONE, 1'b1, 1'b0);

      // SW x2,8(x1)
      send(32'h0020A423, 32'h120);
      exp_dec("sw", 32'h120, 5'd0, 32'h8, ALU_ADD, F_STORE, 1'b1, 1'b0);

      // BLT x1,x2,+8
      send(32'h0020C463, 32'h124);
      exp_dec("blt", 32'h124, 5'd0, 32'h8, ALU_SLT, F_BRANCH, 1'b0, 1'b0);

      // JAL x1,-8
      send(32'hFF9FF0EF, 32'h128);
      exp_dec("jal", 32'h128, 5'd1, 32'hFFFFFFF8, ALU_ADD, F_JAL, 1'b0, 1'b0);

      // ECALL
      send(32'h00000073, 32'h12C);
      exp_dec("ecall", 32'h12C, 5'd0, 32'h0, ALU_ADD, F_SYSTEM, 1'b0, 1'b0);

      // flush drops the incoming instruction
      flush = 1'b1;
      send(32'hFFF10093, 32'h130);
      chk("flush.valid", 32'(bus.decoder_valid), 32'd0);
      flush = 1'b0;

      // drain with nothing incoming
      send(32'h123452B7, 32'h134);
      bus.fetcher_valid = 1'b0;
      step();
      chk("drain.valid", 32'(bus.decoder_valid), 32'd0);

      // reset while holding a stalled instruction
      send(32'hFFF10093, 32'h138);
      chk("prerst.valid", 32'(bus.decoder_valid), 32'd1);
      bus.executor_ready = 1'b0;
      reset = 1'b1;
      step();
      chk("rst2.valid",   32'(bus.decoder_valid), 32'd0);
      chk("rst2.rd",      32'(bus.rd), 32'd0);
      chk("rst2.imm",     bus.imm, 32'd0);
      chk("rst2.alu_imm", 32'(bus.alu_imm), 32'd0);
      chk("rst2.pc",      bus.decoder_pc, 32'd0);
      reset = 1'b0;
      #1;
      chk("rst2.ready", 32'(bus.decoder_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
